// File: rtl/i2c_rx_shifter_pkg.sv
// Shared I2C definitions: byte width and receive-side state encodings.
// Kept here so the transmit side decodes the same states and widths.
package i2c_rx_shifter_pkg;

   localparam int I2C_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_ACK   = 2'd2
   } i2c_state_e;

   // Counter wide enough to hold 0..width inclusive.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/i2c_rx_shifter_if.sv
// Receiver bus: raw I2C lines and controls in, byte/ACK/condition flags out.
// slave is the receiver side, master is whoever drives the lines and consumes results.
interface i2c_rx_shifter_if
   import i2c_rx_shifter_pkg::*;
#(
   parameter int data_width = I2C_DATA_WIDTH
);
   logic                  scl_in;
   logic                  sda_in;
   logic                  enable;
   logic                  clear;
   logic [data_width-1:0] data_out;
   logic                  data_valid;
   logic                  ack_out;
   logic                  ack_valid;
   logic                  start_det;
   logic                  stop_det;
   logic                  busy;

   modport slave (
      input  scl_in, sda_in, enable, clear,
      output data_out, data_valid, ack_out, ack_valid, start_det, stop_det, busy
   );

   modport master (
      output scl_in, sda_in, enable, clear,
      input  data_out, data_valid, ack_out, ack_valid, start_det, stop_det, busy
   );
endinterface

// File: rtl/i2c_rx_shifter_sync_edge.sv
// Synchronizer chain plus history flop for one asynchronous I2C line.
// Level appears sync_stages cycles after the pin; rise/fall are combinational one-cycle strobes.
module i2c_sync_edge #(
   parameter int sync_stages = 2
) (
   input  logic clk,
   input  logic rst_,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [sync_stages-1:0] sync_q;
   logic                   hist_q;

   // Reset to 1 so a released bus looks idle rather than producing a fake edge.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         sync_q <= '1;
         hist_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[sync_stages-2:0], din};
         hist_q <= sync_q[sync_stages-1];
      end
   end

   assign level = sync_q[sync_stages-1];
   assign rise  = level & ~hist_q;
   assign fall  = ~level & hist_q;

endmodule

// File: rtl/i2c_rx_shifter.sv
// I2C receive shifter: START/STOP detection, MSB-first byte capture and ACK sampling.
// data_valid follows a raw SCL edge by at most sync_stages+2 clk; no backpressure, all flags are one-cycle pulses.
module i2c_rx_shifter
   import i2c_rx_shifter_pkg::*;
#(
   parameter int data_width  = I2C_DATA_WIDTH,
   parameter int sync_stages = 2
) (
   input  logic                clk,
   input  logic                rst_,
   i2c_rx_shifter_if.slave     bus
);

   localparam int CW = cnt_width(data_width);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;
   logic start_evt, stop_evt;

   i2c_sync_edge #(.sync_stages(sync_stages)) u_scl_sync (
      .clk   (clk),
      .rst_  (rst_),
      .din   (bus.scl_in),
      .level (scl_lvl),
      .rise  (scl_rise),
      .fall  (scl_fall)
   );

   i2c_sync_edge #(.sync_stages(sync_stages)) u_sda_sync (
      .clk   (clk),
      .rst_  (rst_),
      .din   (bus.sda_in),
      .level (sda_lvl),
      .rise  (sda_rise),
      .fall  (sda_fall)
   );

   // SCL must be high now and last cycle, so a simultaneous SCL edge suppresses both.
   assign start_evt = sda_fall & scl_lvl & ~scl_rise;
   assign stop_evt  = sda_rise & scl_lvl & ~scl_rise;

   i2c_state_e            state_q, state_d;
   logic [data_width-1:0] shift_q, shift_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  ack_seen_q, ack_seen_d;
   logic [data_width-1:0] data_q, data_d;
   logic                  dvld_q, dvld_d;
   logic                  ack_q, ack_d;
   logic                  avld_q, avld_d;
   logic                  start_q, start_d;
   logic                  stop_q, stop_d;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         cnt_q      <= '0;
         ack_seen_q <= 1'b0;
         data_q     <= '0;
         dvld_q     <= 1'b0;
         ack_q      <= 1'b0;
         avld_q     <= 1'b0;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         ack_seen_q <= ack_seen_d;
         data_q     <= data_d;
         dvld_q     <= dvld_d;
         ack_q      <= ack_d;
         avld_q     <= avld_d;
         start_q    <= start_d;
         stop_q     <= stop_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      ack_seen_d = ack_seen_q;
      data_d     = data_q;
      dvld_d     = 1'b0;
      ack_d      = ack_q;
      avld_d     = 1'b0;
      start_d    = start_evt;
      stop_d     = stop_evt;

      if (bus.clear) begin
         state_d    = ST_IDLE;
         shift_d    = '0;
         cnt_d      = '0;
         ack_seen_d = 1'b0;
         data_d     = '0;
         ack_d      = 1'b0;
         start_d    = 1'b0;
         stop_d     = 1'b0;
      end else if (bus.enable) begin
         if (stop_evt) begin
            state_d    = ST_IDLE;
            shift_d    = '0;
            cnt_d      = '0;
            ack_seen_d = 1'b0;
         end else if (start_evt) begin
            state_d    = ST_SHIFT;
            shift_d    = '0;
            cnt_d      = '0;
            ack_seen_d = 1'b0;
         end else begin
            case (state_q)
               ST_SHIFT: begin
                  if (scl_rise) begin
                     shift_d = {shift_q[data_width-2:0], sda_lvl};
                     cnt_d   = cnt_q + CW'(1);
                     if (cnt_q == CW'(data_width - 1)) begin
                        data_d     = shift_d;
                        dvld_d     = 1'b1;
                        state_d    = ST_ACK;
                        ack_seen_d = 1'b0;
                     end
                  end
               end
               // The falling edge that ends the last data bit arrives before the ACK clock; skip it.
               ST_ACK: begin
                  if (scl_rise && !ack_seen_q) begin
                     ack_d      = ~sda_lvl;
                     avld_d     = 1'b1;
                     ack_seen_d = 1'b1;
                  end else if (scl_fall && ack_seen_q) begin
                     state_d    = ST_SHIFT;
                     cnt_d      = '0;
                     ack_seen_d = 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.data_out   = data_q;
   assign bus.data_valid = dvld_q;
   assign bus.ack_out    = ack_q;
   assign bus.ack_valid  = avld_q;
   assign bus.start_det  = start_q;
   assign bus.stop_det   = stop_q;
   assign bus.busy       = (state_q != ST_IDLE);

endmodule
